// File: rtl/color_sensor_emulator.sv
// Emulated TCS3200 colour sensor: programmable per-filter square wave with
// settle blanking after enable or filter-select changes.
module color_sensor_emulator #(
  parameter int unsigned PERIOD_WIDTH  = 16,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned RED_PERIOD    = 800,
  parameter int unsigned GREEN_PERIOD  = 1200,
  parameter int unsigned BLUE_PERIOD   = 1000,
  parameter int unsigned CLEAR_PERIOD  = 400
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [1:0]              colorSelect,
  input  logic                    cfgValid,
  output logic                    cfgReady,
  input  logic [1:0]              cfgColor,
  input  logic [PERIOD_WIDTH-1:0] cfgPeriod,
  output logic                    frequencyOut,
  output logic [7:0]              periodsEmitted
);

  localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned COUNT_W  = 8;

  // Channel encoding follows the sensor's {S3,S2} lines.
  localparam logic [1:0] CH_RED   = 2'b00;
  localparam logic [1:0] CH_CLEAR = 2'b01;
  localparam logic [1:0] CH_BLUE  = 2'b10;
  localparam logic [1:0] CH_GREEN = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;

  logic [1:0]              r_sel_prev;
  logic [PERIOD_WIDTH-1:0] r_period [4];
  logic [PERIOD_WIDTH-1:0] r_active;
  logic [PERIOD_WIDTH-1:0] r_phase;
  logic [SETTLE_W-1:0]     r_settle;
  logic                    r_out;
  logic [COUNT_W-1:0]      r_count;
  logic                    r_cfg_ready;

  logic [PERIOD_WIDTH-1:0] w_active_next;
  logic [PERIOD_WIDTH-1:0] w_phase_next;
  logic [SETTLE_W-1:0]     w_settle_next;
  logic                    w_out_next;
  logic [COUNT_W-1:0]      w_count_next;

  logic                    w_sel_change;
  logic                    w_settle_done;
  logic [PERIOD_WIDTH-1:0] w_new_period;
  logic                    w_new_ok;
  logic                    w_active_off;
  logic                    w_boundary;
  logic [PERIOD_WIDTH-1:0] w_phase_inc;
  logic [PERIOD_WIDTH-1:0] w_half;
  logic                    w_cfg_write;

  // Event decode shared by the next-state and datapath logic.
  always_comb begin
    w_sel_change  = (colorSelect != r_sel_prev);
    w_settle_done = (r_settle == SETTLE_W'(SETTLE_CYCLES - 1));
    w_new_period  = r_period[colorSelect];
    w_new_ok      = (w_new_period >= PERIOD_WIDTH'(2));
    // A channel below 2 cycles is "off": treat every cycle as a boundary so a
    // later write is picked up on the very next edge.
    w_active_off  = (r_active < PERIOD_WIDTH'(2));
    w_boundary    = w_active_off || (r_phase == (r_active - PERIOD_WIDTH'(1)));
    w_phase_inc   = r_phase + PERIOD_WIDTH'(1);
    w_half        = r_active >> 1;
    w_cfg_write   = cfgValid && r_cfg_ready;
  end

  // State register plus all datapath registers and the period table.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_sel_prev  <= 2'b00;
      r_active    <= '0;
      r_phase     <= '0;
      r_settle    <= '0;
      r_out       <= 1'b0;
      r_count     <= '0;
      r_cfg_ready <= 1'b0;
      r_period[CH_RED]   <= PERIOD_WIDTH'(RED_PERIOD);
      r_period[CH_CLEAR] <= PERIOD_WIDTH'(CLEAR_PERIOD);
      r_period[CH_BLUE]  <= PERIOD_WIDTH'(BLUE_PERIOD);
      r_period[CH_GREEN] <= PERIOD_WIDTH'(GREEN_PERIOD);
    end else begin
      r_state     <= w_state_next;
      r_sel_prev  <= colorSelect;
      r_active    <= w_active_next;
      r_phase     <= w_phase_next;
      r_settle    <= w_settle_next;
      r_out       <= w_out_next;
      r_count     <= w_count_next;
      r_cfg_ready <= 1'b1;
      if (w_cfg_write) begin
        r_period[cfgColor] <= cfgPeriod;
      end
    end
  end

  // Next-state logic; disable outranks a select change.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!enable) begin
          w_state_next = ST_IDLE;
        end else if (w_sel_change) begin
          w_state_next = ST_SETTLE;
        end else if (w_settle_done) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          w_state_next = ST_IDLE;
        end else if (w_sel_change) begin
          w_state_next = ST_SETTLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath next values: settle count, phase, active period, output, edge count.
  always_comb begin
    w_active_next = r_active;
    w_phase_next  = r_phase;
    w_settle_next = r_settle;
    w_out_next    = 1'b0;
    w_count_next  = r_count;
    case (r_state)
      ST_IDLE: begin
        if (w_state_next == ST_SETTLE) begin
          w_settle_next = '0;
          w_count_next  = '0;
        end
      end
      ST_SETTLE: begin
        if (w_state_next == ST_SETTLE) begin
          w_settle_next = w_sel_change ? '0 : (r_settle + SETTLE_W'(1));
          w_count_next  = '0;
        end else if (w_state_next == ST_RUN) begin
          // First period starts on the leaving edge.
          w_active_next = w_new_period;
          w_phase_next  = '0;
          w_out_next    = w_new_ok;
          if (w_new_ok) begin
            w_count_next = r_count + COUNT_W'(1);
          end
        end
      end
      ST_RUN: begin
        if (w_state_next == ST_RUN) begin
          if (w_boundary) begin
            // Period reload happens only here, so mid-period writes wait.
            w_active_next = w_new_period;
            w_phase_next  = '0;
            w_out_next    = w_new_ok;
            if (w_new_ok) begin
              w_count_next = r_count + COUNT_W'(1);
            end
          end else begin
            w_phase_next = w_phase_inc;
            w_out_next   = (w_phase_inc < w_half);
          end
        end else if (w_state_next == ST_SETTLE) begin
          w_settle_next = '0;
          w_count_next  = '0;
        end
      end
      default: begin
        w_out_next = 1'b0;
      end
    endcase
  end

  assign cfgReady       = r_cfg_ready;
  assign frequencyOut   = r_out;
  assign periodsEmitted = r_count;

endmodule

// File: tb/tb_color_sensor_emulator.sv
// Bench for color_sensor_emulator: absolute-time behavioural model checked
// every cycle, plus directed scenarios with hand-computed waveform widths.
module tb_color_sensor_emulator;

  localparam int unsigned PW     = 16;
  localparam int          SETTLE = 16;
  localparam int          LIMIT  = 5000;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [1:0]    colorSelect;
  logic          cfgValid;
  logic          cfgReady;
  logic [1:0]    cfgColor;
  logic [PW-1:0] cfgPeriod;
  logic          frequencyOut;
  logic [7:0]    periodsEmitted;

  color_sensor_emulator dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .colorSelect   (colorSelect),
    .cfgValid      (cfgValid),
    .cfgReady      (cfgReady),
    .cfgColor      (cfgColor),
    .cfgPeriod     (cfgPeriod),
    .frequencyOut  (frequencyOut),
    .periodsEmitted(periodsEmitted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (absolute edge numbers) ----------------
  int       n_edge = 0;
  bit       m_valid = 1'b0;
  int       m_per [4];
  bit       m_ready;
  int       m_sel_prev;
  int       m_mode;        // 0 idle, 1 settling, 2 running
  int       m_settle_end;  // edge number at which running begins
  int       m_P;
  int       m_rise;        // edge number at which the current period began
  int       m_cnt;
  bit       m_out;

  task automatic m_start(input int n);
    m_P    = m_per[colorSelect];
    m_rise = n;
    if (m_P >= 2) m_cnt = (m_cnt + 1) % 256;
  endtask

  always @(posedge clk) begin
    n_edge++;
    if (reset) begin
      m_per[0] = 800; m_per[1] = 400; m_per[2] = 1000; m_per[3] = 1200;
      m_ready = 1'b0; m_sel_prev = 0; m_mode = 0; m_cnt = 0; m_P = 0;
      m_rise = 0; m_settle_end = 0; m_out = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (!enable) begin
        m_mode = 0;
      end else if (m_mode == 0 || int'(colorSelect) != m_sel_prev) begin
        m_mode = 1; m_settle_end = n_edge + SETTLE; m_cnt = 0;
      end else if (m_mode == 1 && n_edge == m_settle_end) begin
        m_mode = 2; m_start(n_edge);
      end else if (m_mode == 2 && (m_P < 2 || n_edge == m_rise + m_P)) begin
        m_start(n_edge);
      end
      m_out = (m_mode == 2) && (m_P >= 2) && ((n_edge - m_rise) < m_P / 2);
      if (cfgValid && m_ready) m_per[cfgColor] = int'(cfgPeriod);
      m_ready = 1'b1;
      m_sel_prev = int'(colorSelect);
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_out",   int'(frequencyOut),   int'(m_out));
      chk("model_count", int'(periodsEmitted), m_cnt);
      chk("model_ready", int'(cfgReady),       int'(m_ready));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Counts low samples until a high sample is seen (bounded).
  task automatic wait_rise(output int lows);
    lows = 0;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      if (frequencyOut) return;
      lows++;
    end
  endtask

  // Starting on a high sample, counts high samples; ends on the first low one.
  task automatic meas_high(output int h);
    h = 1;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      if (!frequencyOut) return;
      h++;
    end
  endtask

  // Starting on a low sample, counts low samples; ends on the next rise.
  task automatic meas_low(output int l);
    l = 1;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      if (frequencyOut) return;
      l++;
    end
  endtask

  task automatic write_cfg(input logic [1:0] c, input int p);
    cfgValid  = 1'b1;
    cfgColor  = c;
    cfgPeriod = PW'(p);
  endtask

  int l, h;

  initial begin
    reset = 1'b1; enable = 1'b0; colorSelect = 2'b00;
    cfgValid = 1'b0; cfgColor = 2'b00; cfgPeriod = '0;

    // 1: reset state, red at 800 after 16 settle cycles
    cyc(3);
    chk("rst_out",   int'(frequencyOut),   0);
    chk("rst_ready", int'(cfgReady),       0);
    chk("rst_count", int'(periodsEmitted), 0);
    reset = 1'b0;
    cyc(1);
    chk("ready_after_rst", int'(cfgReady), 1);
    enable = 1'b1;
    wait_rise(l);   chk("t1_settle", l, 16);
    chk("t1_cnt1", int'(periodsEmitted), 1);
    meas_high(h);   chk("t1_high", h, 400);
    meas_low(l);    chk("t1_low", l, 400);
    chk("t1_cnt2", int'(periodsEmitted), 2);
    meas_high(h);   meas_low(l);
    chk("t1_cnt3", int'(periodsEmitted), 3);

    // 2: select change mid-high to green
    cyc(100);
    colorSelect = 2'b11;
    cyc(1);
    chk("t2_out_drop", int'(frequencyOut), 0);
    chk("t2_cnt_clr",  int'(periodsEmitted), 0);
    wait_rise(l);   chk("t2_settle", l + 1, 16);
    chk("t2_cnt1", int'(periodsEmitted), 1);
    meas_high(h);   chk("t2_high", h, 600);
    meas_low(l);    chk("t2_low", l, 600);

    // 3: mid-period write to green does not distort the current period
    cyc(49);
    write_cfg(2'b11, 501);
    cyc(1);
    cfgValid = 1'b0;
    meas_high(h);   chk("t3_high_old", h + 50, 600);
    meas_low(l);    chk("t3_low_old", l, 600);
    meas_high(h);   chk("t3_high_new", h, 250);
    meas_low(l);    chk("t3_low_new", l, 251);

    // 4: disabled blue channel, then re-enable by write
    write_cfg(2'b10, 1);
    cyc(1);
    cfgValid = 1'b0;
    colorSelect = 2'b10;
    cyc(1);
    chk("t4_out_drop", int'(frequencyOut), 0);
    cyc(100);
    chk("t4_out_off", int'(frequencyOut), 0);
    chk("t4_cnt_off", int'(periodsEmitted), 0);
    write_cfg(2'b10, 10);
    cyc(1);
    cfgValid = 1'b0;
    chk("t4_out_write_edge", int'(frequencyOut), 0);
    cyc(1);
    chk("t4_rise_next", int'(frequencyOut), 1);
    chk("t4_cnt1", int'(periodsEmitted), 1);
    meas_high(h);   chk("t4_high", h, 5);
    meas_low(l);    chk("t4_low", l, 5);

    // 5: red programmed to 300, reset mid-high restores 800
    write_cfg(2'b00, 300);
    cyc(1);
    cfgValid = 1'b0;
    colorSelect = 2'b00;
    wait_rise(l);   chk("t5_settle", l, 16);
    meas_high(h);   chk("t5_high300", h, 150);
    meas_low(l);    chk("t5_low300", l, 150);
    cyc(50);
    reset = 1'b1; enable = 1'b0;
    cyc(1);
    chk("t5_rst_out",   int'(frequencyOut),   0);
    chk("t5_rst_ready", int'(cfgReady),       0);
    chk("t5_rst_count", int'(periodsEmitted), 0);
    reset = 1'b0;
    cyc(1);
    enable = 1'b1;
    wait_rise(l);   chk("t5_settle2", l, 16);
    meas_high(h);   chk("t5_high800", h, 400);
    meas_low(l);    chk("t5_low800", l, 400);

    // 6: write blue=64 together with select change to blue
    cyc(10);
    write_cfg(2'b10, 64);
    colorSelect = 2'b10;
    cyc(1);
    cfgValid = 1'b0;
    chk("t6_out_drop", int'(frequencyOut), 0);
    wait_rise(l);   chk("t6_settle", l + 1, 16);
    meas_high(h);   chk("t6_high", h, 32);
    meas_low(l);    chk("t6_low", l, 32);
    meas_high(h);   chk("t6_high2", h, 32);

    // 7: shortest period on blue so the edge counter wraps past 255
    write_cfg(2'b10, 2);
    cyc(1);
    cfgValid = 1'b0;
    cyc(700);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
